// File: rtl/regfile_wb.sv
// Y86-64 architectural register file at the writeback boundary.
// Two bypassed read ports, a committed-only debug port and a write counter.
module regfile_wb #(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wb_en_i,
  input  logic [3:0]       dstE_i,
  input  logic [63:0]      valE_i,
  input  logic [3:0]       dstM_i,
  input  logic [63:0]      valM_i,
  input  logic [3:0]       srcA_i,
  input  logic [3:0]       srcB_i,
  output logic [63:0]      valA_o,
  output logic [63:0]      valB_o,
  input  logic [3:0]       dbg_sel_i,
  output logic [63:0]      dbg_val_o,
  output logic [63:0]      rsp_o,
  output logic [CNT_W-1:0] wr_count_o
);

  localparam logic [3:0] RNONE = 4'hF;

  logic [63:0]      regs_q [15];
  logic [63:0]      regs_d [15];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             we_e;
  logic             we_m;
  logic [1:0]       n_wr;

  // An unknown index leaves every if-condition false, so nothing is written.
  always_comb begin
    we_e   = wb_en_i && (dstE_i != RNONE);
    we_m   = wb_en_i && (dstM_i != RNONE);
    regs_d = regs_q;
    for (int i = 0; i < 15; i++) begin
      if (we_m && (dstM_i == 4'(i))) begin
        regs_d[i] = valM_i;
      end else if (we_e && (dstE_i == 4'(i))) begin
        regs_d[i] = valE_i;
      end
    end
    n_wr = 2'd0;
    if (we_m) begin
      n_wr = 2'd1;
    end
    if (we_e && !(we_m && (dstE_i == dstM_i))) begin
      n_wr = n_wr + 2'd1;
    end
    cnt_d = cnt_q + CNT_W'(n_wr);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= (i == 4) ? RSP_INIT : 64'h0;
      end
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= regs_d[i];
      end
      cnt_q <= cnt_d;
    end
  end

  // M outranks E, matching the collision rule on commit.
  always_comb begin
    valA_o = 64'h0;
    if (srcA_i == RNONE) begin
      valA_o = 64'h0;
    end else if (wb_en_i && (dstM_i == srcA_i)) begin
      valA_o = valM_i;
    end else if (wb_en_i && (dstE_i == srcA_i)) begin
      valA_o = valE_i;
    end else begin
      valA_o = regs_q[srcA_i];
    end
  end

  always_comb begin
    valB_o = 64'h0;
    if (srcB_i == RNONE) begin
      valB_o = 64'h0;
    end else if (wb_en_i && (dstM_i == srcB_i)) begin
      valB_o = valM_i;
    end else if (wb_en_i && (dstE_i == srcB_i)) begin
      valB_o = valE_i;
    end else begin
      valB_o = regs_q[srcB_i];
    end
  end

  always_comb begin
    dbg_val_o = 64'h0;
    if (dbg_sel_i != RNONE) begin
      dbg_val_o = regs_q[dbg_sel_i];
    end
  end

  assign rsp_o      = regs_q[4];
  assign wr_count_o = cnt_q;

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Architectural register file for the Y86-64 pipeline: 15 x 64-bit registers, indices 0..14; 4'hF = RNONE.
- It is the receiving end of the writeback stage. It consumes dstE/valE and dstM/valM from the W-stage register and commits them on the clock edge.
- It serves two combinational read ports (srcA, srcB) to decode, with same-cycle write-through bypass.
- It keeps a committed-write counter and a debug read port for the bench and the halt monitor.

Parameters:
- RSP_INIT, 64'h0, reset value of register 4 (%rsp); all other registers reset to 0.
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  asynchronous active-low reset
- wb_en_i  input  1  W-stage holds a valid instruction (not bubble, not stalled, stat OK); gates all writes
- dstE_i  input  4  E-port destination; 4'hF = no write
- valE_i  input  64  E-port data
- dstM_i  input  4  M-port destination; 4'hF = no write
- valM_i  input  64  M-port data
- srcA_i  input  4  read port A index; 4'hF = none
- srcB_i  input  4  read port B index; 4'hF = none
- valA_o  output  64  read port A data
- valB_o  output  64  read port B data
- dbg_sel_i  input  4  debug read index
- dbg_val_o  output  64  debug read data; committed state only, no bypass
- rsp_o  output  64  committed value of register 4
- wr_count_o  output  CNT_W  number of committed register writes since reset

Behaviour:
- Reset (asynchronous, rst_n_i low):
  - All registers = 0, except reg 4 = RSP_INIT.
  - wr_count_o = 0.
  - Because reads are combinational from state, during reset valA_o/valB_o/dbg_val_o read those reset values, and rsp_o = RSP_INIT.
  - Reset asserted mid-stream discards any write pending on that edge.
  - On deassertion, the first rising edge with wb_en_i=1 commits normally.
- Write, on rising clk_i:
  - Port E commits when wb_en_i=1 and dstE_i != 4'hF.
  - Port M commits when wb_en_i=1 and dstM_i != 4'hF.
  - Both ports may commit in the same cycle. Latency is 1 cycle: the new value is visible in state after the edge.
- Collision: if dstE_i == dstM_i != 4'hF, only valM_i is written (popq %rsp semantics). This counts as one write.
- wb_en_i=0: no register changes and the counter holds. This covers stall and bubble; the zeroed dst fields of a bubble must not write reg 0.
- wr_count_o:
  - Increments by the number of distinct registers written that edge: 0, 1 or 2.
  - Wraps modulo 2^CNT_W.
- Read ports (combinational):
  - srcX == 4'hF -> output 0.
  - Otherwise priority is:
    1. M bypass: wb_en_i=1 and dstM_i == srcX -> valM_i.
    2. E bypass: wb_en_i=1 and dstE_i == srcX -> valE_i.
    3. Committed register value.
  - The M-over-E priority matches the collision rule, so a bypassed value always equals the value committed on the next edge.
- Debug and rsp ports:
  - dbg_val_o: committed value of dbg_sel_i; 0 when dbg_sel_i = 4'hF.
  - rsp_o: committed reg 4, no bypass.
- X-safety: unknown index values must never write; a write requires a definite match.

Test Plan:
- Reset with RSP_INIT=64'h1000 -> rsp_o=64'h1000; dbg_val_o=0 for indices 0..14 except 4; wr_count_o=0; valA_o=0 for srcA_i=4'hF.
- wb_en_i=1, dstE_i=2, valE_i=64'hAA, dstM_i=4'hF; srcA_i=2 in the same cycle -> valA_o=64'hAA before the edge (bypass); after the edge dbg_sel_i=2 reads 64'hAA; wr_count_o=1.
- dstE_i=4, valE_i=64'h1008 and dstM_i=4, valM_i=64'h55 in the same cycle -> srcB_i=4 gives 64'h55 pre-edge; rsp_o=64'h55 post-edge; wr_count_o +1.
- dstE_i=1, valE_i=7, dstM_i=3, valM_i=9 -> after the edge reg1=7, reg3=9; wr_count_o +2.
- wb_en_i=0 with dstE_i=0, valE_i=64'hDEAD -> reg0 unchanged; counter unchanged; srcA_i=0 returns the committed value, not 64'hDEAD.
- Drop rst_n_i between edges after several writes -> immediate reset values with no clock; the write presented at the next edge while still in reset is ignored.
